div_share_arbiter: RTL and testbench

DIV_SHARE_ARBITER -- requirements
Module: div_share_arbiter

---
 rtl/div_share_arbiter.sv | 148 ++++++++++++++
 tb/tb_div_share_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_share_arbiter.sv
// Round-robin arbiter sharing one external divider between two requesters.
// Screens divide-by-zero and overflow, launches the divider, and bounds the wait.
module div_share_arbiter #(
  parameter int TIMEOUT = 24
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        req0,
  input  logic        req1,
  input  logic [7:0]  a0,
  input  logic [7:0]  a1,
  input  logic [15:0] b0,
  input  logic [15:0] b1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [7:0]  rsp_q,
  output logic [7:0]  rsp_r,
  output logic [1:0]  rsp_err,
  output logic        busy,
  output logic        div_clear,
  output logic [7:0]  div_a,
  output logic [15:0] div_b,
  input  logic        div_done,
  input  logic [7:0]  div_q,
  input  logic [7:0]  div_r
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CHECK  = 3'd1;
  localparam logic [2:0] S_LAUNCH = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  localparam logic [7:0] TO = 8'(TIMEOUT);

  logic [2:0]  state;
  logic        rr;
  logic [7:0]  cnt;
  logic [7:0]  lat_a;
  logic [15:0] lat_b;
  logic        lat_id;
  logic        win;

  // rr only breaks ties; a lone requester always wins
  always_comb begin
    win = req1;
    if (req0 && req1) win = rr;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state     <= S_IDLE;
      rr        <= 1'b0;
      cnt       <= 8'd0;
      lat_a     <= 8'd0;
      lat_b     <= 16'd0;
      lat_id    <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_q     <= 8'd0;
      rsp_r     <= 8'd0;
      rsp_err   <= 2'b00;
      busy      <= 1'b0;
      div_clear <= 1'b0;
      div_a     <= 8'd0;
      div_b     <= 16'd0;
    end else begin
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rsp_valid <= 1'b0;
      div_clear <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (req0 || req1) begin
            state  <= S_CHECK;
            busy   <= 1'b1;
            rr     <= ~win;
            lat_id <= win;
            lat_a  <= win ? a1 : a0;
            lat_b  <= win ? b1 : b0;
            gnt0   <= ~win;
            gnt1   <= win;
          end
        end
        S_CHECK: begin
          if (lat_a == 8'd0) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_id    <= lat_id;
            rsp_err   <= 2'b01;
            rsp_q     <= 8'hFF;
            rsp_r     <= 8'hFF;
          end else if (lat_b[15:8] >= lat_a) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_id    <= lat_id;
            rsp_err   <= 2'b10;
            rsp_q     <= 8'hFF;
            rsp_r     <= 8'hFF;
          end else begin
            state     <= S_LAUNCH;
            div_clear <= 1'b1;
            div_a     <= lat_a;
            div_b     <= lat_b;
          end
        end
        S_LAUNCH: begin
          state <= S_WAIT;
          cnt   <= 8'd1;
        end
        S_WAIT: begin
          // a completion on the last allowed cycle still counts
          if (div_done) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_id    <= lat_id;
            rsp_err   <= 2'b00;
            rsp_q     <= div_q;
            rsp_r     <= div_r;
          end else if (cnt == TO) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_id    <= lat_id;
            rsp_err   <= 2'b11;
            rsp_q     <= 8'd0;
            rsp_r     <= 8'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          cnt   <= 8'd0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_share_arbiter.sv
// Bench for div_share_arbiter: directed table, corner sequences,
// and randomized jobs checked against a behavioural job model.
module tb_div_share_arbiter;

  localparam int TO = 24;

  logic        clk = 1'b0;
  logic        clear;
  logic        req0, req1;
  logic [7:0]  a0, a1;
  logic [15:0] b0, b1;
  logic        gnt0, gnt1;
  logic        rsp_valid, rsp_id;
  logic [7:0]  rsp_q, rsp_r;
  logic [1:0]  rsp_err;
  logic        busy, div_clear;
  logic [7:0]  div_a;
  logic [15:0] div_b;
  logic        div_done;
  logic [7:0]  div_q, div_r;

  int total = 0;
  int bad = 0;
  int dly_cfg = 0;
  int dcnt = 0;
  bit armed = 1'b0;

  div_share_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .clear(clear),
    .req0(req0), .req1(req1),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_q(rsp_q), .rsp_r(rsp_r), .rsp_err(rsp_err),
    .busy(busy), .div_clear(div_clear),
    .div_a(div_a), .div_b(div_b),
    .div_done(div_done), .div_q(div_q), .div_r(div_r)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         id;
    logic [7:0] a;
    logic [15:0] b;
    int         d;
    logic [1:0] err;
    logic [7:0] q;
    logic [7:0] r;
    int         lat;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [47:0] all_out();
    return {gnt0, gnt1, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_err,
            busy, div_clear, div_a, div_b};
  endfunction

  // divider: answers dly_cfg cycles after the start pulse (0 = never)
  task automatic step();
    @(negedge clk);
    if (div_clear) begin
      armed = 1'b1;
      dcnt = 0;
      div_done = 1'b0;
    end else if (armed) begin
      dcnt++;
      div_done = (dcnt == dly_cfg);
      if (div_done) armed = 1'b0;
    end else begin
      div_done = 1'b0;
    end
    if (div_a != 8'd0) begin
      div_q = 8'(div_b / {8'd0, div_a});
      div_r = 8'(div_b % {8'd0, div_a});
    end
  endtask

  function automatic void model(input logic [7:0] a, input logic [15:0] b,
                                input int d, output logic [1:0] e,
                                output logic [7:0] q, output logic [7:0] r,
                                output int lat);
    int ai, bi;
    ai = int'(a);
    bi = int'(b);
    if (ai == 0) begin
      e = 2'b01; q = 8'hFF; r = 8'hFF; lat = 2;
    end else if (bi / 256 >= ai) begin
      e = 2'b10; q = 8'hFF; r = 8'hFF; lat = 2;
    end else if (d >= 1 && d <= TO) begin
      e = 2'b00; q = 8'(bi / ai); r = 8'(bi % ai); lat = 3 + d;
    end else begin
      e = 2'b11; q = 8'd0; r = 8'd0; lat = 3 + TO;
    end
  endfunction

  task automatic do_reset();
    clear = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    armed = 1'b0;
    div_done = 1'b0;
    step();
    step();
    chk("reset_outputs", 48'(all_out()), 48'd0);
    clear = 1'b0;
  endtask

  task automatic do_job(input bit r0, input bit r1,
                        input logic [7:0] x0, input logic [15:0] y0,
                        input logic [7:0] x1, input logic [15:0] y1,
                        input int d, input bit eid, input logic [1:0] eerr,
                        input logic [7:0] eq, input logic [7:0] er,
                        input int elat);
    int rsp_at;
    int clears;
    int xg;
    logic hid;
    logic [7:0] hq, hr;
    logic [1:0] he;
    rsp_at = -1;
    clears = 0;
    xg = 0;
    hid = 1'bx;
    hq = 8'hxx;
    hr = 8'hxx;
    he = 2'bxx;
    dly_cfg = d;
    req0 = r0; a0 = x0; b0 = y0;
    req1 = r1; a1 = x1; b1 = y1;
    step();
    chk("gnt0", gnt0, !eid);
    chk("gnt1", gnt1, eid);
    chk("busy_check", busy, 1);
    if (eid) req1 = 1'b0;
    else req0 = 1'b0;
    for (int c = 2; c <= 40 && rsp_at < 0; c++) begin
      step();
      if (div_clear) clears++;
      if (gnt0 || gnt1) xg++;
      if (rsp_valid) begin
        rsp_at = c;
        hid = rsp_id;
        hq = rsp_q;
        hr = rsp_r;
        he = rsp_err;
      end
    end
    chk("rsp_latency", rsp_at, elat);
    chk("rsp_id", hid, eid);
    chk("rsp_err", he, eerr);
    chk("rsp_q", hq, eq);
    chk("rsp_r", hr, er);
    chk("div_clear_count", clears, (eerr == 2'b00 || eerr == 2'b11) ? 1 : 0);
    chk("extra_gnt", xg, 0);
    step();
    chk("idle_after_rsp", {busy, rsp_valid}, 0);
    chk("rsp_hold", {rsp_q, rsp_r, rsp_err}, {hq, hr, he});
  endtask

  task automatic gen_op(output logic [7:0] a, output logic [15:0] b);
    a = (($urandom_range(0, 7)) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
    if (a != 8'd0 && $urandom_range(0, 3) != 0)
      b = 16'($urandom_range(0, int'(a) * 256 - 1));
    else
      b = 16'($urandom);
  endtask

  vec_t tbl[9];

  initial begin
    logic [1:0] e;
    logic [7:0] q, r;
    int lat, d, gn, bz;
    bit w, mrr;
    bit pend[2];
    logic [7:0] pa[2];
    logic [15:0] pb[2];

    tbl[0] = '{0, 8'd7,   16'd200,   10, 2'b00, 8'd28,  8'd4,   13};
    tbl[1] = '{1, 8'd0,   16'd100,   5,  2'b01, 8'hFF,  8'hFF,  2};
    tbl[2] = '{0, 8'd5,   16'h0A00,  5,  2'b10, 8'hFF,  8'hFF,  2};
    tbl[3] = '{0, 8'd3,   16'd100,   0,  2'b11, 8'd0,   8'd0,   27};
    tbl[4] = '{1, 8'd9,   16'd1000,  24, 2'b00, 8'd111, 8'd1,   27};
    tbl[5] = '{1, 8'd9,   16'd1000,  25, 2'b11, 8'd0,   8'd0,   27};
    tbl[6] = '{0, 8'd255, 16'd65279, 1,  2'b00, 8'd255, 8'd254, 4};
    tbl[7] = '{1, 8'd10,  16'h0A00,  3,  2'b10, 8'hFF,  8'hFF,  2};
    tbl[8] = '{0, 8'd10,  16'd2559,  5,  2'b00, 8'd255, 8'd9,   8};

    a0 = 8'd0; a1 = 8'd0; b0 = 16'd0; b1 = 16'd0;
    div_q = 8'd0; div_r = 8'd0;
    do_reset();

    for (int i = 0; i < 9; i++)
      do_job(!tbl[i].id, tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].a, tbl[i].b,
             tbl[i].d, tbl[i].id, tbl[i].err, tbl[i].q, tbl[i].r, tbl[i].lat);

    // both request together after reset: 0 first, 1 held then served
    do_reset();
    do_job(1, 1, 8'd7, 16'd200, 8'd6, 16'd100, 4, 0, 2'b00, 8'd28, 8'd4, 7);
    do_job(0, 1, 8'd7, 16'd200, 8'd6, 16'd100, 2, 1, 2'b00, 8'd16, 8'd4, 5);

    // clear during WAIT cycle 3, then a late div_done
    req0 = 1'b1; a0 = 8'd3; b0 = 16'd100; dly_cfg = 0;
    step();
    req0 = 1'b0;
    step(); step(); step(); step();
    chk("busy_in_wait", busy, 1);
    clear = 1'b1;
    step();
    chk("clear_mid_job", 48'(all_out()), 48'd0);
    clear = 1'b0;
    armed = 1'b0;
    div_done = 1'b1;
    bz = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (rsp_valid || busy || gnt0 || gnt1) bz++;
    end
    chk("late_done_ignored", bz, 0);
    // pointer was reset by clear, so requester 0 wins the tie
    do_job(1, 1, 8'd4, 16'd9, 8'd2, 16'd9, 1, 0, 2'b00, 8'd2, 8'd1, 4);
    do_job(0, 1, 8'd4, 16'd9, 8'd2, 16'd9, 1, 1, 2'b00, 8'd4, 8'd1, 4);

    // request raised while busy and dropped before idle is forgotten
    req0 = 1'b1; a0 = 8'd0; b0 = 16'd1;
    step();
    req0 = 1'b0;
    req1 = 1'b1; a1 = 8'd5; b1 = 16'd10;
    step();
    chk("err_rsp_at_t2", rsp_valid, 1);
    req1 = 1'b0;
    gn = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (gnt0 || gnt1 || busy) gn++;
    end
    chk("dropped_req_forgotten", gn, 0);

    // random jobs against the behavioural model
    do_reset();
    mrr = 1'b0;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 2; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          gen_op(pa[i], pb[i]);
        end
      if (!pend[0] && !pend[1]) begin
        w = 1'($urandom_range(0, 1));
        pend[w] = 1'b1;
        gen_op(pa[w], pb[w]);
      end
      w = (pend[0] && pend[1]) ? mrr : pend[1];
      mrr = !w;
      d = $urandom_range(0, 30);
      model(pa[w], pb[w], d, e, q, r, lat);
      do_job(pend[0], pend[1], pa[0], pb[0], pa[1], pb[1], d, w, e, q, r, lat);
      pend[w] = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
